// File: rtl/command_status_executor.sv
// command_status_executor: runs each bridge command as one backend transaction and queues one status per command; `define COMMAND_STATUS_EXECUTOR_TIMEOUT_EN adds a response timeout
module command_status_executor #(
  parameter int STATUS_DEPTH   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_command_valid,
  output logic                          o_command_ready,
  input  logic                          i_command,
  output logic                          o_status_valid,
  input  logic                          i_status_ready,
  output logic                          o_status,
  output logic                          o_req_valid,
  input  logic                          i_req_ready,
  output logic                          o_req_write,
  input  logic                          i_rsp_valid,
  input  logic                          i_rsp_error,
  output logic                          o_busy,
  output logic [$clog2(STATUS_DEPTH):0] o_status_count
);
  localparam int AW = $clog2(STATUS_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;
  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          mem_q [STATUS_DEPTH];
  logic          push, pop, push_err, timeout;
  if (STATUS_DEPTH < 2 || (STATUS_DEPTH & (STATUS_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("command_status_executor: STATUS_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end
`ifdef COMMAND_STATUS_EXECUTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  assign timeout = tmr_q == TW'(TIMEOUT_CYCLES);
  // cycles spent in WAIT_RSP without a response; held at zero in every other state
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) tmr_q <= '0;
    else if (state_q != WAIT_RSP) tmr_q <= '0;
    else if (!i_rsp_valid && !timeout) tmr_q <= tmr_q + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  assign push            = state_q == WAIT_RSP && (i_rsp_valid || timeout);
  assign push_err        = i_rsp_valid ? i_rsp_error : 1'b1;
  assign o_status_valid  = cnt_q != '0;
  assign pop             = o_status_valid && i_status_ready;
  assign o_status        = o_status_valid && mem_q[rp_q];
  assign o_command_ready = i_rst_n && state_q == IDLE && cnt_q < (AW+1)'(STATUS_DEPTH);
  assign o_req_valid     = state_q == ISSUE;
  assign o_req_write     = o_req_valid && write_q;
  assign o_busy          = state_q != IDLE;
  assign o_status_count  = cnt_q;
  // next-state: one command at a time, IDLE -> ISSUE -> WAIT_RSP -> IDLE
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    case (state_q)
      IDLE: if (i_command_valid && o_command_ready) begin
        state_d = ISSUE;
        write_d = !i_command;
      end
      ISSUE:    state_d = i_req_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: state_d = push ? IDLE : WAIT_RSP;
      default:  state_d = IDLE;
    endcase
  end
  // FSM, latched write flag and FIFO bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  // status storage; contents are only observed while the count covers them
  always_ff @(posedge i_clk)
    if (push) mem_q[wp_q] <= push_err;
endmodule

// File: tb/tb_command_status_executor.sv
// tb_command_status_executor: table, directed and random transactions checked against a status-queue model
module tb_command_status_executor;
  logic       clk = 0, rst_n = 0;
  logic       i_command_valid = 0, i_command = 0, i_status_ready = 0;
  logic       i_req_ready = 0, i_rsp_valid = 0, i_rsp_error = 0;
  logic       o_command_ready, o_status_valid, o_status, o_req_valid, o_req_write, o_busy;
  logic [2:0] o_status_count;
  int         n_pass = 0, n_total = 0;
  bit         model[$];
  bit         m_push = 0, m_err = 0, rand_rdy = 0;
  typedef struct {bit cmd; int req_wait; int rsp_wait; bit err; bit on_hs; bit exp_write; bit exp_status;} vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  command_status_executor dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_command_valid(i_command_valid), .o_command_ready(o_command_ready), .i_command(i_command),
    .o_status_valid(o_status_valid), .i_status_ready(i_status_ready), .o_status(o_status),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_write(o_req_write),
    .i_rsp_valid(i_rsp_valid), .i_rsp_error(i_rsp_error),
    .o_busy(o_busy), .o_status_count(o_status_count)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_ready"}, o_command_ready, 0);
    chk({tag, "_status_valid"}, o_status_valid, 0);
    chk({tag, "_status"}, o_status, 0);
    chk({tag, "_req_valid"}, o_req_valid, 0);
    chk({tag, "_req_write"}, o_req_write, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_count"}, o_status_count, 0);
  endtask

  task automatic step();
    bit pop, held;
    logic hs;
    if (rand_rdy) i_status_ready = 1'($urandom_range(0, 1));
    chk("status_valid", o_status_valid, model.size() != 0);
    pop  = o_status_valid && i_status_ready;
    held = o_status_valid && !i_status_ready;
    hs   = o_status;
    if (pop && model.size() != 0) chk("status_order", o_status, model[0]);
    @(posedge clk);
    if (pop && model.size() != 0) model.delete(0);
    if (m_push) model.push_back(m_err);
    m_push = 0;
    #1;
    chk("status_count", o_status_count, model.size());
    if (held) begin
      chk("hold_valid", o_status_valid, 1);
      chk("hold_value", o_status, hs);
    end
  endtask

  task automatic txn(input bit cmd, input int rw, input int sw, input bit err, input bit on_hs,
                     input bit exp_write, input bit exp_status, input bit rdy_rsp);
    int guard = 0;
    while (!o_command_ready && guard < 200) begin step(); guard++; end
    chk("cmd_ready_wait", guard < 200, 1);
    i_command_valid = 1; i_command = cmd;
    step();
    i_command_valid = 0; i_command = 1'($urandom);
    chk("req_valid", o_req_valid, 1);
    chk("req_write", o_req_write, exp_write);
    chk("cmd_ready_busy", o_command_ready, 0);
    repeat (rw) begin
      step();
      chk("req_hold_valid", o_req_valid, 1);
      chk("req_hold_write", o_req_write, exp_write);
    end
    i_req_ready = 1; i_rsp_valid = on_hs; i_rsp_error = 1;
    step();
    i_req_ready = 0; i_rsp_valid = 0;
    chk("req_done", o_req_valid, 0);
    repeat (sw) begin step(); chk("busy_wait", o_busy, 1); end
    i_rsp_valid = 1; i_rsp_error = err; m_push = 1; m_err = exp_status;
    if (rdy_rsp) i_status_ready = 1;
    step();
    if (rdy_rsp) i_status_ready = 0;
    i_rsp_valid = 0;
    chk("idle_after_rsp", o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 1, 0, 0, 1, 0};
    vecs[1] = '{1, 5, 0, 1, 0, 0, 1};
    vecs[2] = '{0, 2, 3, 1, 1, 1, 1};
    vecs[3] = '{1, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{1, 1, 2, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 1, 0, 1, 1};
    #2;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("ready_after_reset", o_command_ready, 1);
    i_status_ready = 1;
    foreach (vecs[i])
      txn(vecs[i].cmd, vecs[i].req_wait, vecs[i].rsp_wait, vecs[i].err, vecs[i].on_hs,
          vecs[i].exp_write, vecs[i].exp_status, 0);
    repeat (3) step();
    i_status_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bit c = 1'($urandom_range(0, 1)), e = 1'($urandom_range(0, 1));
      txn(c, 0, 1, e, 0, c == 0, e, 0);
    end
    repeat (3) begin step(); chk("full_ready", o_command_ready, 0); end
    i_status_ready = 1;
    step();
    chk("ready_after_pop", o_command_ready, 1);
    repeat (4) step();
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      bit c = 1'($urandom_range(0, 1)), e = 1'($urandom_range(0, 1)), h = 1'($urandom_range(0, 1));
      txn(c, $urandom_range(0, 3), $urandom_range(0, 4), e, h, c == 0, e, 0);
    end
    rand_rdy = 0;
    i_status_ready = 1;
    repeat (6) step();
    i_status_ready = 0;
    txn(0, 0, 0, 1, 0, 1, 1, 0);
    txn(1, 0, 0, 0, 0, 0, 0, 0);
    txn(1, 1, 1, 1, 0, 0, 1, 1);
    chk("push_pop_count", o_status_count, 2);
    i_status_ready = 1;
    repeat (4) step();
`ifdef COMMAND_STATUS_EXECUTOR_TIMEOUT_EN
    i_command_valid = 1; i_command = 1;
    step();
    i_command_valid = 0; i_req_ready = 1;
    step();
    i_req_ready = 0;
    repeat (16) begin step(); chk("busy_before_timeout", o_busy, 1); end
    m_push = 1; m_err = 1;
    step();
    chk("idle_after_timeout", o_busy, 0);
    repeat (3) step();
    i_rsp_valid = 1; i_rsp_error = 0;
    step();
    i_rsp_valid = 0;
    repeat (3) step();
`else
    txn(1, 0, 100, 0, 0, 0, 0, 0);
    repeat (3) step();
`endif
    i_status_ready = 0;
    txn(0, 0, 0, 0, 0, 1, 0, 0);
    txn(1, 0, 1, 1, 0, 0, 1, 0);
    i_command_valid = 1; i_command = 1;
    step();
    i_command_valid = 0; i_req_ready = 1;
    step();
    i_req_ready = 0;
    chk("pre_reset_count", o_status_count, 2);
    #2 rst_n = 0;
    model.delete();
    #1;
    chk_zero("mid_reset");
    i_rsp_valid = 1; i_rsp_error = 0;
    repeat (2) @(posedge clk);
    #1 i_rsp_valid = 0; rst_n = 1;
    step();
    chk("post_reset_busy", o_busy, 0);
    chk("post_reset_ready", o_command_ready, 1);
    i_status_ready = 1;
    txn(1, 0, 0, 1, 0, 0, 1, 0);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/command_status_executor.md
Name: command_status_executor

Overview:
- Slave-side stage that sits directly downstream of the command/status bus bridge. It consumes the bridge's command stream (WRITE/READ), executes each command as one transaction on a simple backend request/response port, and returns one status (OK/ERROR) per command.
- A small status FIFO decouples backend completion from status back-pressure, so a new command can be accepted while earlier statuses are still waiting to be taken.

Parameters:
- STATUS_DEPTH, 4, status FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 16, cycles in WAIT_RSP before a timeout; only used with the optional feature; must be at least 1.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_command_valid  input  1  command handshake valid.
- o_command_ready  output  1  command handshake ready.
- i_command  input  1  Command enum: 0 = WRITE, 1 = READ.
- o_status_valid  output  1  status handshake valid.
- i_status_ready  input  1  status handshake ready.
- o_status  output  1  Status enum: 0 = OK, 1 = ERROR.
- o_req_valid  output  1  backend request valid.
- i_req_ready  input  1  backend request ready.
- o_req_write  output  1  1 = write request, 0 = read request.
- i_rsp_valid  input  1  backend response strobe (one cycle, no ready).
- i_rsp_error  input  1  backend response error flag, sampled with i_rsp_valid.
- o_busy  output  1  high when the FSM is not in IDLE.
- o_status_count  output  $clog2(STATUS_DEPTH)+1  current status FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE.
  - FIFO is empty; all outputs are 0 (o_command_ready, o_status_valid, o_status, o_req_valid, o_req_write, o_busy, o_status_count).
  - Asserting reset mid-transaction drops the in-flight command; no status is ever produced for it.
- A handshake completes on a cycle where valid && ready.
- FSM states and transitions:
  - IDLE: o_command_ready = (o_status_count < STATUS_DEPTH), so a free FIFO slot is always reserved before a command is taken. On a command handshake: latch i_command into the write flag and go to ISSUE.
  - ISSUE: o_req_valid = 1 and o_req_write = latched flag, both registered and held stable until i_req_ready. On the request handshake go to WAIT_RSP.
  - WAIT_RSP: on i_rsp_valid, push i_rsp_error (0 = OK, 1 = ERROR) into the FIFO and go to IDLE.
- i_rsp_valid outside WAIT_RSP is ignored, including a response arriving in the same cycle as the request handshake.
- o_command_ready is low in every state except IDLE, so at most one command is outstanding.
- Latency, minimum case:
  - Command accepted at cycle T → o_req_valid at T+1.
  - Request handshake at T+1 → response sampled no earlier than T+2.
  - Response at cycle R → o_status_valid at R+1.
- Status FIFO:
  - First-word output driven directly from storage; o_status_valid = !empty.
  - Pop on a status handshake.
  - Push and pop in the same cycle are both performed and the count is unchanged. The push from WAIT_RSP never overflows because of the slot reserved in IDLE.
  - Pointers are $clog2(STATUS_DEPTH) bits and wrap naturally; the count saturates at neither end.
- Ordering: statuses leave in exactly the order their commands were accepted.
- o_status and o_status_valid must not change while o_status_valid && !i_status_ready.

Optional Feature:
- Macro: COMMAND_STATUS_EXECUTOR_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RSP and increments each cycle without a response.
  - When it reaches TIMEOUT_CYCLES, push ERROR and go to IDLE.
  - A late response for that transaction is ignored under the normal out-of-state rule.
  - A response arriving on the timeout cycle itself wins: push its error flag, not the timeout ERROR.
- Not defined: no counter logic is present and WAIT_RSP waits indefinitely.

Test Plan:
- Reset release, then WRITE with i_req_ready=1 and a response with error=0 two cycles after the request → o_req_write=1 at T+1, status OK valid at R+1; o_status_count goes 1 → 0 on pop.
- READ with i_req_ready held low for 5 cycles → o_req_valid stays 1 with o_req_write=0 stable throughout; handshake on cycle 6; response error=1 → status ERROR.
- i_status_ready=0 while issuing 4 commands with STATUS_DEPTH=4 → o_status_count reaches 4 and o_command_ready=0 from then on. Raise ready → statuses drain in order and o_command_ready returns to 1 after the first pop.
- Status pop and response push in the same cycle with count=2 → count stays 2 and the FIFO contents and order are correct across pointer wrap (more than 8 total transactions).
- With COMMAND_STATUS_EXECUTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, no response → ERROR pushed 16 cycles after entering WAIT_RSP; a stray i_rsp_valid 3 cycles later pushes nothing. Without the macro → o_busy stays high for 100 cycles.
- Reset asserted in WAIT_RSP with 2 statuses queued → all outputs 0 immediately, count 0, and a response during reset is ignored.
